// File: rtl/fp_pkg.sv
// Shared definitions for the float-to-integer conversion slice: rounding
// modes, default format widths and the field layout of the packed input word.
package fp_pkg;

  // Rounding mode encoding carried alongside each input word
  typedef enum logic [1:0] {
    TRUNC = 2'b00,
    RNE   = 2'b01,
    RHA   = 2'b10,
    RSVD  = 2'b11
  } round_mode_e;

  // Default format: 5-bit exponent, 16-bit explicit mantissa, 16-bit result
  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 16;
  localparam int DEF_BIAS  = 15;
  localparam int DEF_INT_W = 16;

  // The packed word is {sign, exp, man} with the mantissa in the low bits
  localparam int MAN_LSB      = 0;
  localparam int DEF_EXP_LSB  = MAN_LSB + DEF_MAN_W;
  localparam int DEF_SIGN_POS = DEF_EXP_LSB + DEF_EXP_W;

  // Bit position of the exponent LSB for a given mantissa width
  function automatic int exp_lsb(input int man_w);
    return MAN_LSB + man_w;
  endfunction

  // Bit position of the sign for given exponent and mantissa widths
  function automatic int sign_pos(input int exp_w, input int man_w);
    return MAN_LSB + man_w + exp_w;
  endfunction

endpackage

// File: rtl/fp_to_int_pipe_if.sv
// Valid/ready bundle for the float-to-integer converter: an input word with
// its rounding mode, and the saturated integer result with its flags.
interface fp_to_int_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 16,
  parameter int INT_W = 16
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   a;
  logic [1:0]             mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [INT_W-1:0]       c;
  logic                   ovf;
  logic                   inexact;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, c, ovf, inexact
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, c, ovf, inexact
  );

endinterface

// File: rtl/fp_align_shift.sv
// Aligns the mantissa to the integer binary point: produces the integer
// magnitude, the guard bit and sticky OR of the discarded fraction, and an
// early overflow flag when significant bits land beyond the magnitude width.
module fp_align_shift
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int BIAS  = DEF_BIAS,
  parameter int INT_W = DEF_INT_W
) (
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0] i_man,
  output logic [INT_W:0]   o_mag,
  output logic             o_guard,
  output logic             o_sticky,
  output logic             o_ovf_pre
);

  // One extra magnitude bit lets -2^(INT_W-1) and rounding carries be seen
  localparam int MAG_W  = INT_W + 1;
  localparam int WIDE_W = MAN_W + MAG_W;

  int                 exp_int;
  int                 shift;
  logic [WIDE_W-1:0]  wide;
  logic [2*MAN_W-1:0] ext;

  // Left shift for large exponents, right shift with guard/sticky otherwise
  always_comb begin
    exp_int              = 0;
    exp_int[EXP_W-1:0]   = i_exp;
    shift                = exp_int - BIAS - (MAN_W - 1);
    wide                 = '0;
    ext                  = '0;
    o_guard              = 1'b0;
    o_sticky             = 1'b0;
    o_ovf_pre            = 1'b0;
    if (shift > 0) begin
      if (shift >= MAG_W) begin
        o_ovf_pre = |i_man;
      end else begin
        wide = {{MAG_W{1'b0}}, i_man} << shift;
      end
    end else if (-shift > MAN_W) begin
      o_sticky = |i_man;
    end else begin
      ext      = {i_man, {MAN_W{1'b0}}} >> (-shift);
      wide     = {{MAG_W{1'b0}}, ext[2*MAN_W-1:MAN_W]};
      o_guard  = ext[MAN_W-1];
      o_sticky = |ext[MAN_W-2:0];
    end
    o_ovf_pre = o_ovf_pre | (|wide[WIDE_W-1:MAG_W]);
    o_mag     = wide[MAG_W-1:0];
  end

endmodule

// File: rtl/fp_to_int_pipe.sv
// Two-stage float-to-integer converter with valid/ready flow control.
// Stage 1 holds the aligned magnitude, guard/sticky, sign and mode; stage 2
// holds the rounded, signed and saturated result with its flags.
module fp_to_int_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int BIAS  = DEF_BIAS,
  parameter int INT_W = DEF_INT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [1:0]           i_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [INT_W-1:0]     o_c,
  output logic                 o_ovf,
  output logic                 o_inexact
);

  localparam int MAG_W    = INT_W + 1;
  localparam int E_LSB    = exp_lsb(MAN_W);
  localparam int S_POS    = sign_pos(EXP_W, MAN_W);
  localparam logic [MAG_W:0]   POS_LIM = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic [MAG_W:0]   NEG_LIM = {2'b00, 1'b1, {(INT_W-1){1'b0}}};
  localparam logic [MAG_W:0]   ONE     = {{MAG_W{1'b0}}, 1'b1};
  localparam logic [INT_W-1:0] MAX_C   = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_C   = {1'b1, {(INT_W-1){1'b0}}};

  logic              s1_v_q, s1_v_d;
  logic [MAG_W-1:0]  s1_mag_q, s1_mag_d;
  logic              s1_guard_q, s1_guard_d;
  logic              s1_sticky_q, s1_sticky_d;
  logic              s1_sign_q, s1_sign_d;
  logic              s1_ovf_q, s1_ovf_d;
  round_mode_e       s1_mode_q, s1_mode_d;
  logic              s2_v_q, s2_v_d;
  logic [INT_W-1:0]  s2_c_q, s2_c_d;
  logic              s2_ovf_q, s2_ovf_d;
  logic              s2_inexact_q, s2_inexact_d;

  logic [MAG_W-1:0]  al_mag;
  logic              al_guard, al_sticky, al_ovf_pre;
  logic              s2_load;
  logic              round_up, sat;
  logic [MAG_W:0]    mag_r, neg_r;

  fp_align_shift #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .BIAS  (BIAS),
    .INT_W (INT_W)
  ) u_align (
    .i_exp     (i_a[S_POS-1:E_LSB]),
    .i_man     (i_a[E_LSB-1:MAN_LSB]),
    .o_mag     (al_mag),
    .o_guard   (al_guard),
    .o_sticky  (al_sticky),
    .o_ovf_pre (al_ovf_pre)
  );

  // Handshake: stage 1 advances whenever it is empty or stage 2 takes its word
  always_comb begin
    s2_load     = s1_v_q && (!s2_v_q || i_ready);
    o_ready     = !s1_v_q || !s2_v_q || i_ready;
    s1_v_d      = o_ready ? i_valid : s1_v_q;
    s1_mag_d    = o_ready ? al_mag : s1_mag_q;
    s1_guard_d  = o_ready ? al_guard : s1_guard_q;
    s1_sticky_d = o_ready ? al_sticky : s1_sticky_q;
    s1_sign_d   = o_ready ? i_a[S_POS] : s1_sign_q;
    s1_ovf_d    = o_ready ? al_ovf_pre : s1_ovf_q;
    s1_mode_d   = o_ready ? round_mode_e'(i_mode) : s1_mode_q;
    s2_v_d      = s2_load ? 1'b1 : (i_ready ? 1'b0 : s2_v_q);
  end

  // Round the stage-1 magnitude, apply the sign, then saturate
  always_comb begin
    round_up = 1'b0;
    case (s1_mode_q)
      RNE:     round_up = s1_guard_q & (s1_sticky_q | s1_mag_q[0]);
      RHA:     round_up = s1_guard_q;
      default: round_up = 1'b0;
    endcase
    mag_r        = {1'b0, s1_mag_q} + (round_up ? ONE : '0);
    neg_r        = ~mag_r + ONE;
    sat          = s1_ovf_q || (s1_sign_q ? (mag_r > NEG_LIM) : (mag_r > POS_LIM));
    s2_c_d       = s2_c_q;
    s2_ovf_d     = s2_ovf_q;
    s2_inexact_d = s2_inexact_q;
    if (s2_load) begin
      if (sat) begin
        s2_c_d = s1_sign_q ? MIN_C : MAX_C;
      end else begin
        s2_c_d = s1_sign_q ? neg_r[INT_W-1:0] : mag_r[INT_W-1:0];
      end
      s2_ovf_d     = sat;
      s2_inexact_d = (s1_guard_q | s1_sticky_q) & !sat;
    end
  end

  // Pipeline registers; reset empties both stages and clears the outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v_q       <= 1'b0;
      s1_mag_q     <= '0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_ovf_q     <= 1'b0;
      s1_mode_q    <= TRUNC;
      s2_v_q       <= 1'b0;
      s2_c_q       <= '0;
      s2_ovf_q     <= 1'b0;
      s2_inexact_q <= 1'b0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_mag_q     <= s1_mag_d;
      s1_guard_q   <= s1_guard_d;
      s1_sticky_q  <= s1_sticky_d;
      s1_sign_q    <= s1_sign_d;
      s1_ovf_q     <= s1_ovf_d;
      s1_mode_q    <= s1_mode_d;
      s2_v_q       <= s2_v_d;
      s2_c_q       <= s2_c_d;
      s2_ovf_q     <= s2_ovf_d;
      s2_inexact_q <= s2_inexact_d;
    end
  end

  assign o_valid   = s2_v_q;
  assign o_c       = s2_c_q;
  assign o_ovf     = s2_ovf_q;
  assign o_inexact = s2_inexact_q;

endmodule
